// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and the MEM/WB field bundle for the write-back stage.
//   REG_ZERO    hardwired-zero register index
//   WIDTH       data path width
//   NREGS       number of architectural registers
//   REG_AW      register address width
//   memWb_t     MEM/WB pipeline register fields
package mips_pkg;
    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic regWrite;
        logic memToReg;
        logic [REG_AW-1:0] rd;
        logic [WIDTH-1:0] aluResult;
        logic [WIDTH-1:0] memData;
    } memWb_t;
endpackage

// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: bus between the MEM/ID/EX stages (master) and the write-back register file (slave).
//   master drives: wbEnable, wbFlush, regWriteIn, memToRegIn, rdIn, aluResultIn, memDataIn,
//                  readRegRs, readRegRt, dbgAddr
//   master sees:   readRs, readRt, wbData, wbRd, wbRegWrite, dbgData
interface reg_file_wb_if;
    import mips_pkg::*;
    logic wbEnable;
    logic wbFlush;
    logic regWriteIn;
    logic memToRegIn;
    logic [REG_AW-1:0] rdIn;
    logic [WIDTH-1:0] aluResultIn;
    logic [WIDTH-1:0] memDataIn;
    logic [REG_AW-1:0] readRegRs;
    logic [REG_AW-1:0] readRegRt;
    logic [WIDTH-1:0] readRs;
    logic [WIDTH-1:0] readRt;
    logic [WIDTH-1:0] wbData;
    logic [REG_AW-1:0] wbRd;
    logic wbRegWrite;
    logic [REG_AW-1:0] dbgAddr;
    logic [WIDTH-1:0] dbgData;
    modport master (
        output wbEnable, wbFlush, regWriteIn, memToRegIn, rdIn, aluResultIn, memDataIn,
               readRegRs, readRegRt, dbgAddr,
        input  readRs, readRt, wbData, wbRd, wbRegWrite, dbgData
    );
    modport slave (
        input  wbEnable, wbFlush, regWriteIn, memToRegIn, rdIn, aluResultIn, memDataIn,
               readRegRs, readRegRt, dbgAddr,
        output readRs, readRt, wbData, wbRd, wbRegWrite, dbgData
    );
endinterface

// File: rtl/reg_array.sv
// reg_array: NREGS x WIDTH storage with one write port and three async read ports.
//   clk, reset       clock, async active-high clear of every entry
//   we, wAddr, wData write port (caller guarantees wAddr != 0 when we=1)
//   rAddrA/B/C       read addresses; rDataA/B/C raw contents, no bypass
module reg_array
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic we,
    input  logic [REG_AW-1:0] wAddr,
    input  logic [WIDTH-1:0] wData,
    input  logic [REG_AW-1:0] rAddrA,
    input  logic [REG_AW-1:0] rAddrB,
    input  logic [REG_AW-1:0] rAddrC,
    output logic [WIDTH-1:0] rDataA,
    output logic [WIDTH-1:0] rDataB,
    output logic [WIDTH-1:0] rDataC
);
    logic [WIDTH-1:0] regs [NREGS];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wAddr] <= wData;
        end
    end
    assign rDataA = regs[rAddrA];
    assign rDataB = regs[rAddrB];
    assign rDataC = regs[rAddrC];
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: MEM/WB pipeline register, write-back mux and bypassed register file reads.
//   clk, reset  clock, async active-high reset of MEM/WB and all registers
//   bus         reg_file_wb_if.slave: MEM-stage inputs, ID read ports, WB outputs, debug port
module reg_file_wb #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    reg_file_wb_if.slave bus
);
    import mips_pkg::*;
    memWb_t mw;
    logic [WIDTH-1:0] arrRs, arrRt;
    // A flush only needs to kill the write; the remaining fields simply hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mw <= '0;
        else if (bus.wbFlush) mw.regWrite <= 1'b0;
        else if (bus.wbEnable) mw <= '{regWrite: bus.regWriteIn, memToReg: bus.memToRegIn,
                                       rd: bus.rdIn, aluResult: bus.aluResultIn,
                                       memData: bus.memDataIn};
    end
    assign bus.wbData = mw.memToReg ? mw.memData : mw.aluResult;
    assign bus.wbRd = mw.rd;
    // Masking rd=0 here keeps both the array write and the bypass from ever touching r0.
    assign bus.wbRegWrite = mw.regWrite && mw.rd != REG_ZERO;
    reg_array #(.NREGS(NREGS), .WIDTH(WIDTH)) uArray (
        .clk(clk),
        .reset(reset),
        .we(bus.wbRegWrite),
        .wAddr(mw.rd),
        .wData(bus.wbData),
        .rAddrA(bus.readRegRs),
        .rAddrB(bus.readRegRt),
        .rAddrC(bus.dbgAddr),
        .rDataA(arrRs),
        .rDataB(arrRt),
        .rDataC(bus.dbgData)
    );
    assign bus.readRs = bus.readRegRs == REG_ZERO ? '0 :
                        (bus.wbRegWrite && mw.rd == bus.readRegRs) ? bus.wbData : arrRs;
    assign bus.readRt = bus.readRegRt == REG_ZERO ? '0 :
                        (bus.wbRegWrite && mw.rd == bus.readRegRt) ? bus.wbData : arrRt;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int nTests = 0;
    int nFails = 0;
    reg_file_wb_if bus();
    reg_file_wb uDut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    // Advance one rising edge and return to the falling edge for driving/sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic mem(input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] md);
        bus.regWriteIn = we;
        bus.memToRegIn = m2r;
        bus.rdIn = rd;
        bus.aluResultIn = alu;
        bus.memDataIn = md;
    endtask
    initial begin
        bus.wbEnable = 0;
        bus.wbFlush = 0;
        mem(0, 0, 0, 0, 0);
        bus.readRegRs = 0;
        bus.readRegRt = 0;
        bus.dbgAddr = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        check("rst_wbRegWrite", {31'd0, bus.wbRegWrite}, 0);
        check("rst_wbData", bus.wbData, 0);
        for (int i = 0; i < 32; i++) begin
            bus.readRegRs = i[4:0];
            bus.readRegRt = 5'(31 - i);
            bus.dbgAddr = i[4:0];
            #1;
            check($sformatf("rst_rs%0d", i), bus.readRs, 0);
            check($sformatf("rst_rt%0d", 31 - i), bus.readRt, 0);
            check($sformatf("rst_dbg%0d", i), bus.dbgData, 0);
        end
        // ALU write to r5: bypass first, array one edge later
        @(negedge clk);
        mem(1, 0, 5, 32'h1234_5678, 0);
        bus.wbEnable = 1;
        bus.readRegRs = 5;
        bus.dbgAddr = 5;
        step();
        bus.wbEnable = 0;
        #1;
        check("w5_bypass", bus.readRs, 32'h1234_5678);
        check("w5_wbRd", {27'd0, bus.wbRd}, 5);
        check("w5_wbRegWrite", {31'd0, bus.wbRegWrite}, 1);
        check("w5_dbg_precommit", bus.dbgData, 0);
        step();
        check("w5_dbg_commit", bus.dbgData, 32'h1234_5678);
        // load data selected over ALU result into r8
        mem(1, 1, 8, 32'h1, 32'hDEAD_BEEF);
        bus.wbEnable = 1;
        step();
        bus.wbEnable = 0;
        bus.readRegRt = 8;
        bus.dbgAddr = 8;
        #1;
        check("w8_wbData", bus.wbData, 32'hDEAD_BEEF);
        check("w8_rt_bypass", bus.readRt, 32'hDEAD_BEEF);
        step();
        check("w8_dbg", bus.dbgData, 32'hDEAD_BEEF);
        bus.dbgAddr = 5;
        #1;
        check("w8_r5_kept", bus.dbgData, 32'h1234_5678);
        // write to r0 is discarded
        mem(1, 0, 0, 32'hFFFF_FFFF, 0);
        bus.wbEnable = 1;
        step();
        bus.wbEnable = 0;
        bus.readRegRt = 0;
        bus.dbgAddr = 0;
        #1;
        check("w0_wbRegWrite", {31'd0, bus.wbRegWrite}, 0);
        check("w0_wbData", bus.wbData, 32'hFFFF_FFFF);
        check("w0_rt", bus.readRt, 0);
        step();
        check("w0_dbg", bus.dbgData, 0);
        // stall holds r3=0xA despite new inputs, flush wins over enable
        mem(1, 0, 3, 32'hA, 0);
        bus.wbEnable = 1;
        step();
        bus.wbEnable = 0;
        mem(1, 0, 3, 32'hB, 0);
        bus.readRegRs = 3;
        bus.dbgAddr = 3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_rs%0d", i), bus.readRs, 32'hA);
            step();
        end
        bus.wbFlush = 1;
        bus.wbEnable = 1;
        step();
        bus.wbFlush = 0;
        bus.wbEnable = 0;
        #1;
        check("flush_wbRegWrite", {31'd0, bus.wbRegWrite}, 0);
        check("flush_rs", bus.readRs, 32'hA);
        step();
        check("flush_dbg", bus.dbgData, 32'hA);
        // async reset between capture and commit of r7
        mem(1, 0, 7, 32'h55, 0);
        bus.wbEnable = 1;
        step();
        bus.wbEnable = 0;
        bus.readRegRs = 7;
        bus.readRegRt = 8;
        bus.dbgAddr = 5;
        #1;
        check("r7_bypass", bus.readRs, 32'h55);
        reset = 1;
        #1;
        check("arst_rs", bus.readRs, 0);
        check("arst_rt", bus.readRt, 0);
        check("arst_wbData", bus.wbData, 0);
        check("arst_wbRd", {27'd0, bus.wbRd}, 0);
        check("arst_wbRegWrite", {31'd0, bus.wbRegWrite}, 0);
        check("arst_dbg", bus.dbgData, 0);
        step();
        reset = 0;
        step();
        bus.dbgAddr = 7;
        #1;
        check("arst_r7_dbg", bus.dbgData, 0);
        check("arst_r7_rs", bus.readRs, 0);
        bus.dbgAddr = 3;
        #1;
        check("arst_r3_dbg", bus.dbgData, 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end
endmodule
